// File: rtl/hazard_stall_controller_if.sv
// Pipeline-to-hazard-controller bundle: per-stage hazard inputs and the
// stage enable/bubble/flush controls driven back into the 5-stage pipe.
interface hazard_stall_controller_if;
    logic        MemRead_EX;
    logic [4:0]  RT_EX;
    logic [4:0]  RS_ID;
    logic [4:0]  RT_ID;
    logic        UseRT_ID;
    logic        BranchTaken_EX;
    logic        MemAccess_MEM;
    logic        MemReady;
    logic        HaltReq;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXWrite;
    logic        IDEXBubble;
    logic        EXMEMWrite;
    logic        MEMWBBubble;
    logic        HaltAck;
    logic        MemTimeout;
    logic [15:0] StallCount;
    logic [15:0] FreezeCount;

    modport master (
        output MemRead_EX, RT_EX, RS_ID, RT_ID, UseRT_ID, BranchTaken_EX,
               MemAccess_MEM, MemReady, HaltReq,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble,
               EXMEMWrite, MEMWBBubble, HaltAck, MemTimeout, StallCount, FreezeCount
    );

    modport slave (
        input  MemRead_EX, RT_EX, RS_ID, RT_ID, UseRT_ID, BranchTaken_EX,
               MemAccess_MEM, MemReady, HaltReq,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble,
               EXMEMWrite, MEMWBBubble, HaltAck, MemTimeout, StallCount, FreezeCount
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush/freeze sequencer with halt-drain handshake for the 5-stage MIPS pipe.
// Define HAZARD_STATS_EN to build the StallCount/FreezeCount statistics counters.
module hazard_stall_controller #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    hazard_stall_controller_if.slave  bus
);
    localparam int WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t              state_q, state_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                timed_out_q;
    logic                mem_timeout_q;

    logic mem_wait, freeze, loaduse;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble;

    assign mem_wait = bus.MemAccess_MEM && !bus.MemReady;
    assign freeze   = mem_wait && !timed_out_q;
    assign loaduse  = bus.MemRead_EX && (bus.RT_EX != 5'd0) &&
                      ((bus.RT_EX == bus.RS_ID) || (bus.UseRT_ID && (bus.RT_EX == bus.RT_ID)));

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Once timed out, the counter sits at WAIT_MAX so timed_out_q holds until the wait ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_q    <= '0;
            timed_out_q   <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else if (MEM_TIMEOUT == 0 || !mem_wait) begin
            wait_cnt_q  <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
                timed_out_q   <= 1'b1;
                mem_timeout_q <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latches are inferred.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (!reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.HaltReq) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
                DRAIN: begin
                    if (!bus.HaltReq)                 state_d = RUN;
                    else if (drain_cnt_q == DRAIN_LAST) state_d = HALTED;
                    else                              drain_cnt_d = drain_cnt_q + 1'b1;
                end
                HALTED: if (!bus.HaltReq) state_d = RUN;
                default: state_d = RUN;
            endcase
            // A taken branch still latches its target while draining; the flush covers any load-use.
            if (bus.BranchTaken_EX) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (state_q != RUN || loaduse) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.IFIDWrite   = ifid_write;
    assign bus.IFIDFlush   = ifid_flush;
    assign bus.IDEXWrite   = idex_write;
    assign bus.IDEXBubble  = idex_bubble;
    assign bus.EXMEMWrite  = exmem_write;
    assign bus.MEMWBBubble = memwb_bubble;
    assign bus.HaltAck     = reset && (state_q == HALTED);
    assign bus.MemTimeout  = reset && mem_timeout_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, freeze_cnt_q;
    logic        stall_hit;

    assign stall_hit = reset && !freeze && !bus.BranchTaken_EX && (state_q == RUN) && loaduse;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (stall_hit && stall_cnt_q != 16'hFFFF)   stall_cnt_q  <= stall_cnt_q + 1'b1;
            if (freeze && freeze_cnt_q != 16'hFFFF)     freeze_cnt_q <= freeze_cnt_q + 1'b1;
        end
    end

    assign bus.StallCount  = reset ? stall_cnt_q  : 16'h0000;
    assign bus.FreezeCount = reset ? freeze_cnt_q : 16'h0000;
`else
    assign bus.StallCount  = 16'h0000;
    assign bus.FreezeCount = 16'h0000;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: dut_a uses default parameters, dut_b (MEM_TIMEOUT=4) mirrors the
// same inputs for the timeout scenario. Expected control vectors are hand-derived.
module tb_hazard_stall_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_controller_if hif_a ();
    hazard_stall_controller_if hif_b ();

    assign hif_b.MemRead_EX     = hif_a.MemRead_EX;
    assign hif_b.RT_EX          = hif_a.RT_EX;
    assign hif_b.RS_ID          = hif_a.RS_ID;
    assign hif_b.RT_ID          = hif_a.RT_ID;
    assign hif_b.UseRT_ID       = hif_a.UseRT_ID;
    assign hif_b.BranchTaken_EX = hif_a.BranchTaken_EX;
    assign hif_b.MemAccess_MEM  = hif_a.MemAccess_MEM;
    assign hif_b.MemReady       = hif_a.MemReady;
    assign hif_b.HaltReq        = hif_a.HaltReq;

    hazard_stall_controller dut_a (.clk(clk), .reset(reset), .bus(hif_a.slave));
    hazard_stall_controller #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(4)) dut_b (.clk(clk), .reset(reset), .bus(hif_b.slave));

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite, MEMWBBubble, HaltAck, MemTimeout}
    localparam logic [8:0] V_DEF    = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] V_RST    = 9'b0_0_1_1_1_1_1_0_0;
    localparam logic [8:0] V_STALL  = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] V_BRANCH = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] V_FREEZE = 9'b0_0_0_0_0_0_1_0_0;
    localparam logic [8:0] V_HALTED = 9'b0_0_0_1_1_1_0_1_0;

    typedef struct {
        string       tag;
        bit          sel;
        logic [8:0]  ctl;
        bit          chk_cnt;
        logic [15:0] stall;
        logic [15:0] frz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic exp_push(input string tag, input bit sel, input logic [8:0] ctl);
        exp_t e;
        e.tag = tag; e.sel = sel; e.ctl = ctl; e.chk_cnt = 1'b0; e.stall = '0; e.frz = '0;
        sb.push_back(e);
    endtask

    task automatic exp_cnt(input string tag, input bit sel, input logic [8:0] ctl,
                           input int stall, input int frz);
        exp_t e;
        e.tag = tag; e.sel = sel; e.ctl = ctl; e.chk_cnt = 1'b1;
`ifdef HAZARD_STATS_EN
        e.stall = 16'(stall); e.frz = 16'(frz);
`else
        e.stall = 16'h0000; e.frz = 16'h0000;
        if (stall < 0 || frz < 0) e.stall = 16'hFFFF;
`endif
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [8:0]  got;
        logic [15:0] got_st, got_fz;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel) begin
                got    = {hif_b.PCWrite, hif_b.IFIDWrite, hif_b.IFIDFlush, hif_b.IDEXWrite, hif_b.IDEXBubble,
                          hif_b.EXMEMWrite, hif_b.MEMWBBubble, hif_b.HaltAck, hif_b.MemTimeout};
                got_st = hif_b.StallCount;
                got_fz = hif_b.FreezeCount;
            end else begin
                got    = {hif_a.PCWrite, hif_a.IFIDWrite, hif_a.IFIDFlush, hif_a.IDEXWrite, hif_a.IDEXBubble,
                          hif_a.EXMEMWrite, hif_a.MEMWBBubble, hif_a.HaltAck, hif_a.MemTimeout};
                got_st = hif_a.StallCount;
                got_fz = hif_a.FreezeCount;
            end
            check({e.tag, ".ctl"}, 32'(got), 32'(e.ctl));
            if (e.chk_cnt) begin
                check({e.tag, ".stall"}, 32'(got_st), 32'(e.stall));
                check({e.tag, ".freeze"}, 32'(got_fz), 32'(e.frz));
            end
        end
    end

    task automatic idle();
        hif_a.MemRead_EX = 1'b0; hif_a.RT_EX = 5'd0; hif_a.RS_ID = 5'd0; hif_a.RT_ID = 5'd0;
        hif_a.UseRT_ID = 1'b0; hif_a.BranchTaken_EX = 1'b0; hif_a.MemAccess_MEM = 1'b0;
        hif_a.MemReady = 1'b0; hif_a.HaltReq = 1'b0;
    endtask

    // Each cycle starts from idle inputs, driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_lu(input logic [4:0] rt_ex, input logic [4:0] rs_id);
        hif_a.MemRead_EX = 1'b1; hif_a.RT_EX = rt_ex; hif_a.RS_ID = rs_id;
    endtask

    task automatic set_wait();
        hif_a.MemAccess_MEM = 1'b1; hif_a.MemReady = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle();
        tick(); exp_cnt("rst_a", 0, V_RST, 0, 0); exp_push("rst_b", 1, V_RST);
        tick(); reset = 1'b1; exp_push("rel", 0, V_DEF);

        // load-use through rs, through rt, and the rt==0 / rt-unused non-hazards
        tick(); set_lu(5'd8, 5'd8); exp_push("lu_rs", 0, V_STALL);
        tick(); exp_cnt("lu_next", 0, V_DEF, 1, 0);
        tick(); set_lu(5'd0, 5'd0); exp_push("lu_r0", 0, V_DEF);
        tick(); set_lu(5'd5, 5'd1); hif_a.RT_ID = 5'd5; hif_a.UseRT_ID = 1'b1; exp_push("lu_rt", 0, V_STALL);
        tick(); set_lu(5'd5, 5'd1); hif_a.RT_ID = 5'd5; exp_push("lu_rt_unused", 0, V_DEF);
        tick(); set_lu(5'd8, 5'd8); hif_a.BranchTaken_EX = 1'b1; exp_push("br_lu", 0, V_BRANCH);
        tick(); exp_cnt("br_next", 0, V_DEF, 2, 0);

        // five-cycle memory wait; branch and load-use are ignored while frozen
        for (int i = 0; i < 5; i++) begin
            tick(); set_wait();
            if (i == 2) begin set_lu(5'd8, 5'd8); hif_a.BranchTaken_EX = 1'b1; end
            exp_push("mw_frz", 0, V_FREEZE);
        end
        tick(); hif_a.MemAccess_MEM = 1'b1; hif_a.MemReady = 1'b1; exp_cnt("mw_done", 0, V_DEF, 2, 5);

        // halt with a branch during drain
        tick(); hif_a.HaltReq = 1'b1; exp_push("h_req", 0, V_DEF);
        tick(); hif_a.HaltReq = 1'b1; exp_push("h_d0", 0, V_STALL);
        tick(); hif_a.HaltReq = 1'b1; hif_a.BranchTaken_EX = 1'b1; exp_push("h_d1_br", 0, V_BRANCH);
        tick(); hif_a.HaltReq = 1'b1; exp_push("h_d2", 0, V_STALL);
        tick(); hif_a.HaltReq = 1'b1; exp_push("h_ack", 0, V_HALTED);
        tick(); hif_a.HaltReq = 1'b1; exp_push("h_hold", 0, V_HALTED);
        tick(); exp_push("h_drop", 0, V_HALTED);
        tick(); exp_push("h_run", 0, V_DEF);

        // halt request withdrawn mid-drain
        tick(); hif_a.HaltReq = 1'b1; exp_push("ab_req", 0, V_DEF);
        tick(); hif_a.HaltReq = 1'b1; exp_push("ab_d0", 0, V_STALL);
        tick(); exp_push("ab_drop", 0, V_STALL);
        tick(); exp_push("ab_run", 0, V_DEF);

        // halt under a two-cycle freeze: drain entry deferred
        tick(); hif_a.HaltReq = 1'b1; set_wait(); exp_push("hf_frz0", 0, V_FREEZE);
        tick(); hif_a.HaltReq = 1'b1; set_wait(); exp_push("hf_frz1", 0, V_FREEZE);
        tick(); hif_a.HaltReq = 1'b1; exp_push("hf_enter", 0, V_DEF);
        for (int i = 0; i < 3; i++) begin
            tick(); hif_a.HaltReq = 1'b1; exp_push("hf_drain", 0, V_STALL);
        end
        tick(); hif_a.HaltReq = 1'b1; exp_push("hf_ack", 0, V_HALTED);
        tick(); exp_push("hf_drop", 0, V_HALTED);
        tick(); exp_cnt("hf_run", 0, V_DEF, 2, 7);

        // reset clears counters and dut_b's sticky timeout from the earlier wait
        tick(); reset = 1'b0; exp_cnt("rst2_a", 0, V_RST, 0, 0); exp_push("rst2_b", 1, V_RST);
        tick(); reset = 1'b1; exp_push("rst2_rel_b", 1, V_DEF);

        // timeout on dut_b (MEM_TIMEOUT=4)
        for (int i = 0; i < 4; i++) begin
            tick(); set_wait(); exp_push("to_frz", 1, V_FREEZE);
        end
        tick(); set_wait(); exp_push("to_rel", 1, V_DEF | 9'd1); exp_push("to_a_frz", 0, V_FREEZE);
        tick(); set_wait(); exp_push("to_sat", 1, V_DEF | 9'd1);
        tick(); hif_a.MemAccess_MEM = 1'b1; hif_a.MemReady = 1'b1; exp_push("to_sticky", 1, V_DEF | 9'd1);
        tick(); exp_push("to_idle", 1, V_DEF | 9'd1);
        tick(); set_wait(); exp_push("to_refrz", 1, V_FREEZE | 9'd1);

        // reset mid-freeze on dut_b, then mid-drain on dut_a
        tick(); reset = 1'b0; set_wait(); exp_push("rst_frz", 1, V_RST);
        tick(); reset = 1'b1; exp_push("rst_frz_rel", 1, V_DEF);
        tick(); hif_a.HaltReq = 1'b1; exp_push("rd_req", 0, V_DEF);
        tick(); hif_a.HaltReq = 1'b1; exp_push("rd_d0", 0, V_STALL);
        tick(); reset = 1'b0; hif_a.HaltReq = 1'b1; exp_push("rd_rst", 0, V_RST);
        tick(); reset = 1'b1; exp_push("rd_rel", 0, V_DEF);

        @(negedge clk);
        #1;
        if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
